// File: rtl/nios2_nios2_cpu_oci_pkg.sv
// Shared types and jdo field positions for the OCI memory arbiter slice.
package nios2_nios2_cpu_oci_pkg;

  typedef enum logic [1:0] {IDLE, AV_RD, JT_RD} state_t;

  typedef enum logic {AV, JT} grant_t;

  localparam int JDO_RDREQ_BIT = 34;
  localparam int JDO_DATA_LSB  = 3;
  localparam int JDO_ADDR_LSB  = 17;

endpackage

// File: rtl/nios2_nios2_cpu_ocimem_jtag_cmd.sv
// Decodes JTAG ocimem strobes into a one-deep command latch with sticky overrun.
module nios2_nios2_cpu_ocimem_jtag_cmd
  import nios2_nios2_cpu_oci_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [37:0]       jdo,
  input  logic [ADDR_W-1:0] mon_areg,
  input  logic              op_done,
  output logic              areg_load,
  output logic [ADDR_W-1:0] areg_load_val,
  output logic              req,
  output logic              req_wr,
  output logic [ADDR_W-1:0] req_addr,
  output logic [31:0]       req_wdata,
  output logic              busy,
  output logic              overrun
);

  logic        pend_q;
  logic        pend_wr_q;
  logic [31:0] pend_wdata_q;
  logic        any_strobe;
  logic        multi_strobe;
  logic        accept;
  logic        new_op;
  logic        new_wr;
  logic        unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // pend_q covers both a waiting command and a read in flight, so any
  // strobe while it is set is an overrun; ocimem_a wins same-cycle ties.
  always_comb begin
    any_strobe    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    multi_strobe  = (take_action_ocimem_a & take_action_ocimem_b)
                  | (take_action_ocimem_a & take_no_action_ocimem_a)
                  | (take_action_ocimem_b & take_no_action_ocimem_a);
    accept        = any_strobe & ~pend_q & ~reset;
    new_wr        = ~take_action_ocimem_a & take_action_ocimem_b;
    new_op        = accept & (take_action_ocimem_a ? jdo[JDO_RDREQ_BIT] : 1'b1);
    areg_load     = accept & take_action_ocimem_a;
    areg_load_val = jdo[JDO_ADDR_LSB +: ADDR_W];
    req           = pend_q | new_op;
    req_wr        = pend_q ? pend_wr_q : new_wr;
    req_addr      = areg_load ? areg_load_val : mon_areg;
    req_wdata     = pend_q ? pend_wdata_q : jdo[JDO_DATA_LSB +: 32];
    busy          = req & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q       <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_wdata_q <= '0;
      overrun      <= 1'b0;
    end else begin
      if (op_done) begin
        pend_q <= 1'b0;
      end else if (new_op) begin
        pend_q       <= 1'b1;
        pend_wr_q    <= new_wr;
        pend_wdata_q <= jdo[JDO_DATA_LSB +: 32];
      end
      if ((any_strobe & pend_q) | multi_strobe) overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/nios2_nios2_cpu_ocimem_arbiter.sv
// Round-robin arbiter sharing the single-port OCI RAM between Avalon and JTAG.
module nios2_nios2_cpu_ocimem_arbiter
  import nios2_nios2_cpu_oci_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [37:0]       jdo,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  output logic [1:0]        dbg_state
);

  // Handshake: an Avalon transfer completes on the cycle av_waitrequest is
  // low while av_read/av_write is high; the master holds its inputs until then.
  state_t            state_q, state_d;
  grant_t            last_grant_q, grant_d;
  logic              av_req;
  logic              op_done;
  logic              areg_inc;
  logic              dreg_load;
  logic              areg_load;
  logic [ADDR_W-1:0] areg_load_val;
  logic              jt_req;
  logic              jt_wr;
  logic [ADDR_W-1:0] jt_addr;
  logic [31:0]       jt_wdata;

  assign dbg_state = state_q;

  nios2_nios2_cpu_ocimem_jtag_cmd #(.ADDR_W(ADDR_W)) u_jtag_cmd (
    .clk                     (clk),
    .reset                   (reset),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .jdo                     (jdo),
    .mon_areg                (MonAReg),
    .op_done                 (op_done),
    .areg_load               (areg_load),
    .areg_load_val           (areg_load_val),
    .req                     (jt_req),
    .req_wr                  (jt_wr),
    .req_addr                (jt_addr),
    .req_wdata               (jt_wdata),
    .busy                    (jtag_busy),
    .overrun                 (jtag_overrun)
  );

  always_comb begin
    state_d        = state_q;
    grant_d        = last_grant_q;
    av_req         = av_read | av_write;
    av_waitrequest = 1'b1;
    av_readdata    = '0;
    ram_addr       = MonAReg;
    ram_wren       = 1'b0;
    ram_byteen     = 4'h0;
    ram_wdata      = '0;
    op_done        = 1'b0;
    areg_inc       = 1'b0;
    dreg_load      = 1'b0;
    // Outputs held at their idle values during reset so no write escapes.
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (jt_req && (!av_req || last_grant_q == AV)) begin
            grant_d  = JT;
            ram_addr = jt_addr;
            if (jt_wr) begin
              ram_wren   = 1'b1;
              ram_byteen = 4'hF;
              ram_wdata  = jt_wdata;
              op_done    = 1'b1;
              areg_inc   = 1'b1;
            end else begin
              state_d = JT_RD;
            end
          end else if (av_req) begin
            grant_d  = AV;
            ram_addr = av_address;
            if (av_write) begin
              ram_wren       = 1'b1;
              ram_byteen     = av_byteenable;
              ram_wdata      = av_writedata;
              av_waitrequest = 1'b0;
            end else begin
              state_d = AV_RD;
            end
          end
        end
        AV_RD: begin
          av_waitrequest = 1'b0;
          av_readdata    = ram_rdata;
          state_d        = IDLE;
        end
        JT_RD: begin
          dreg_load = 1'b1;
          areg_inc  = 1'b1;
          op_done   = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= AV;
      MonDReg      <= '0;
      MonAReg      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= grant_d;
      if (dreg_load) MonDReg <= ram_rdata;
      if (areg_inc) MonAReg <= MonAReg + 1'b1;
      else if (areg_load) MonAReg <= areg_load_val;
    end
  end

endmodule

// File: doc/nios2_nios2_cpu_ocimem_arbiter.md
Name: nios2_nios2_cpu_ocimem_arbiter

Overview:
Shares the single-port on-chip debug RAM (OCI memory) between two requesters: the CPU's Avalon debug-memory slave and the JTAG debug path. The JTAG path issues commands as sysclk-domain take_action/take_no_action strobes with the jdo payload. The block holds the debugger address register (MonAReg) and the read-back register (MonDReg). It sequences single-word RAM reads and writes, arbitrates round-robin, and presents MonDReg back to the JTAG scan chain.

Parameters:
ADDR_W, 8, OCI RAM word-address width
DATA_W, 32, RAM/Avalon data width (fixed 32; jdo layout depends on it)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
take_action_ocimem_a  in  1  JTAG: load MonAReg from jdo; optional read
take_action_ocimem_b  in  1  JTAG: write jdo data at MonAReg, then increment
take_no_action_ocimem_a  in  1  JTAG: read at MonAReg into MonDReg, then increment
jdo  in  38  JTAG payload
av_address  in  ADDR_W  Avalon word address
av_read  in  1  Avalon read
av_write  in  1  Avalon write
av_writedata  in  32  Avalon write data
av_byteenable  in  4  Avalon byte enables
av_readdata  out  32  Avalon read data
av_waitrequest  out  1  Avalon stall
ram_addr  out  ADDR_W  RAM address
ram_wren  out  1  RAM write enable
ram_byteen  out  4  RAM byte enables
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data; registered, 1-cycle latency
MonDReg  out  32  JTAG read-back register
MonAReg  out  ADDR_W  current JTAG address
jtag_busy  out  1  JTAG command pending or in flight
jtag_overrun  out  1  sticky: JTAG strobe arrived while one was pending

Behaviour:
- Reset values: MonDReg=0, MonAReg=0, av_waitrequest=1, av_readdata=0, ram_wren=0, jtag_busy=0, jtag_overrun=0, state=IDLE, last_grant=AV.
- Clock and reset: clk only; reset is synchronous and active-high. Reset mid-operation aborts any in-flight access, drops pending JTAG commands, and asserts no RAM write.
- JTAG decode:
  - ocimem_a loads MonAReg<=jdo[ADDR_W+16:17] immediately, with no arbitration.
  - If jdo[34]=1, ocimem_a also queues a read.
  - ocimem_b queues a write of jdo[34:3] with byteen=4'hF.
  - no_action_ocimem_a queues a read.
- JTAG queue and strobe conflicts:
  - One-deep pending latch. jtag_busy is high from the strobe cycle until the op completes.
  - A new strobe while pending is ignored and sets jtag_overrun; only reset clears it.
  - If several strobes arrive in one cycle, ocimem_a wins and the others set jtag_overrun.
- FSM states: IDLE, AV_RD, JT_RD.
- Arbitration in IDLE:
  - JTAG requests are pending-latch or same-cycle strobe. Avalon requests are av_read|av_write.
  - If both request, grant the requester opposite last_grant. A lone requester is granted directly.
- Avalon write: completes in the grant cycle. ram_wren=1, av_waitrequest=0; stay IDLE.
- Avalon read:
  - Grant cycle drives ram_addr with waitrequest=1, then goes to AV_RD.
  - In AV_RD, av_readdata=ram_rdata and waitrequest=0 for exactly one cycle, then IDLE.
  - Latency is 2 cycles.
  - av_read and av_write both high: write wins.
- JTAG write: completes in the grant cycle. MonAReg increments modulo 2^ADDR_W the same cycle.
- JTAG read:
  - Grant cycle drives ram_addr=MonAReg, then goes to JT_RD.
  - In JT_RD, MonDReg<=ram_rdata and MonAReg increments, then IDLE.
- Avalon inputs are held by the master while waitrequest=1; an ungranted master sees waitrequest=1.
- MonAReg wraps from 2^ADDR_W-1 to 0.

Decomposition:
- Shared package nios2_nios2_cpu_oci_pkg holds:
  - the state enum (IDLE, AV_RD, JT_RD);
  - jdo field constants: JDO_RDREQ_BIT=34, JDO_DATA_LSB=3, JDO_ADDR_LSB=17;
  - the grant enum (AV, JT).
- Optional sub-module nios2_nios2_cpu_ocimem_jtag_cmd: strobe decode, pending latch, overrun.
- The arbiter/FSM stays in the top module.

Test Plan:
- Reset, then idle → av_waitrequest=1, MonDReg=0, MonAReg=0, jtag_busy=0.
- ocimem_a with address 0x10 and jdo[34]=0, then ocimem_b with data 0xDEADBEEF, then ocimem_a with address 0x10 and jdo[34]=1 → RAM[0x10]=0xDEADBEEF; MonDReg=0xDEADBEEF two cycles after the last strobe; MonAReg=0x11.
- Avalon write 0x12345678 @0x20, then Avalon read @0x20 → write has waitrequest=0 in the same cycle; read returns 0x12345678 at cycle +1 with waitrequest=0.
- Avalon read and JTAG read raised in the same cycle with last_grant=AV → JTAG served first, Avalon completes 2 cycles later; repeat with last_grant=JT → Avalon first.
- MonAReg=0xFF, then no_action_ocimem_a → MonDReg=RAM[0xFF], MonAReg=0x00.
- Second strobe while JTAG pending under continuous Avalon traffic → jtag_overrun=1 and stays 1; reset asserted in JT_RD → MonDReg=0 and no RAM write.
